// File: rtl/cp0_intr_pkg.sv
// ----------------------------------------------------------------------------
// cp0_intr_pkg: shared types and constants for the CP0 interrupt unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cp0_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_e;

  localparam logic [1:0] ADDR_COUNT   = 2'd0;
  localparam logic [1:0] ADDR_COMPARE = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int         IM_BASE    = 8;
  localparam logic [2:0] TIMER_LINE = 3'd7;
  localparam logic [4:0] CAUSE_INT  = 5'd0;

  // Highest set bit wins; line 7 (timer) therefore outranks every external line.
  function automatic logic [2:0] highest_line(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_intr_ctrl_irq_sync_edge.sv
// ----------------------------------------------------------------------------
// irq_sync_edge: 2-flop synchroniser followed by a rising-edge detector. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/cp0_intr_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_intr_ctrl: interrupt sources, Count/Compare timer, req/ack toward CP0. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cp0_intr_ctrl
  import cp0_intr_pkg::*;
#(
  parameter int NUM_IRQ = 6,
  parameter int DIV     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        status,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [1:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               int_req,
  output logic [2:0]         int_line,
  input  logic               int_ack,
  input  logic               eret,
  output logic               timer_int
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_REQ     = REQ;
  localparam logic [1:0] ST_SERVICE = SERVICE;

  localparam int           PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [1:0]    r_state;
  logic          r_req;
  logic [2:0]    r_line;
  logic          r_timer_int;
  logic [7:0]    r_pend;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic [PW-1:0] r_presc;

  logic [6:0]    w_edge;
  logic [7:0]    w_pend_nxt;
  logic [7:0]    w_elig;
  logic [2:0]    w_top;
  logic          w_tick;
  logic          w_count_wr;
  logic          w_compare_wr;
  logic          w_pending_wr;
  logic [31:0]   w_count_inc;
  logic          w_match;
  logic          w_ack_take;
  logic          w_unused_ok;

  // Lines without a physical input keep a constant-zero edge so pending stays clear.
  for (genvar k = 0; k < 7; k++) begin : g_line
    if (k < NUM_IRQ) begin : g_used
      irq_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq_in[k]),
        .rise     (w_edge[k])
      );
    end else begin : g_unused
      assign w_edge[k] = 1'b0;
    end
  end

  assign w_count_wr   = wr_en && (wr_addr == ADDR_COUNT);
  assign w_compare_wr = wr_en && (wr_addr == ADDR_COMPARE);
  assign w_pending_wr = wr_en && (wr_addr == ADDR_PENDING);

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_count_inc = r_count + 32'd1;
  assign w_match     = w_tick && !w_count_wr && (w_count_inc == r_compare);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_presc   <= '0;
    end else begin
      if (w_count_wr) begin
        r_count <= wr_data;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_compare_wr) r_compare <= wr_data;
    end
  end

  assign w_ack_take = (r_state == ST_REQ) && int_ack;

  // Ordering encodes precedence: clears first, then sets, then the COMPARE-write clear.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pending_wr) w_pend_nxt = w_pend_nxt & ~wr_data[7:0];
    if (w_ack_take && (r_line != TIMER_LINE)) w_pend_nxt[r_line] = 1'b0;
    w_pend_nxt[6:0] = w_pend_nxt[6:0] | w_edge;
    if (w_match) w_pend_nxt[TIMER_LINE] = 1'b1;
    if (w_compare_wr) w_pend_nxt[TIMER_LINE] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 8'd0;
      r_timer_int <= 1'b0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_timer_int <= r_pend[TIMER_LINE];
    end
  end

  assign w_elig = r_pend & status[IM_BASE +: 8] & {8{status[0]}};
  assign w_top  = highest_line(w_elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_line  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_line  <= w_top;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_SERVICE;
          end else if (!w_elig[r_line]) begin
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (eret) r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      ADDR_COUNT:   rd_data = r_count;
      ADDR_COMPARE: rd_data = r_compare;
      ADDR_PENDING: rd_data = {24'd0, r_pend};
      default:      rd_data = 32'd0;
    endcase
  end

  assign int_req   = r_req;
  assign int_line  = r_line;
  assign timer_int = r_timer_int;

  assign w_unused_ok = ^{status[31:16], status[7:1]};

endmodule

`default_nettype wire

// File: tb/tb_cp0_intr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cp0_intr_ctrl: directed self-checking bench for cp0_intr_ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cp0_intr_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  irq_in;
  logic [31:0] status;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        int_req;
  logic [2:0]  int_line;
  logic        int_ack;
  logic        eret;
  logic        timer_int;

  int total;
  int bad;

  cp0_intr_ctrl #(.NUM_IRQ(6), .DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .status    (status),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .int_req   (int_req),
    .int_line  (int_line),
    .int_ack   (int_ack),
    .eret      (eret),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    irq_in  = '0;
    status  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    int_ack = 1'b0;
    eret    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    irq_in  = '0;
    status  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    int_ack = 1'b0;
    eret    = 1'b0;
    rd_addr = 2'd1;
    repeat (2) @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", int_req); end
    total++; if (int_line !== 3'd0) begin bad++; $display("FAIL reset_line got %0d want 0", int_line); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL reset_timer got %b want 0", timer_int); end
    total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare got %h want ffffffff", rd_data); end
    rd_addr = 2'd0; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_count got %h want 0", rd_data); end
    rd_addr = 2'd2; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_pending got %h want 0", rd_data); end
    rd_addr = 2'd3; #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rsvd got %h want 0", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_ext_irq();
    do_reset();
    status  = 32'h0000_0101;
    rd_addr = 2'd2;
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ext_req_early got %b want 0", int_req); end
    total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL ext_pending_set got %h want 1", rd_data); end
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL ext_req got %b want 1", int_req); end
    total++; if (int_line !== 3'd0) begin bad++; $display("FAIL ext_line got %0d want 0", int_line); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ext_ack_req got %b want 0", int_req); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL ext_ack_pending got %h want 0", rd_data); end
    irq_in[0] = 1'b0;
    @(negedge clk);
    irq_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ext_service_hold got %b want 0", int_req); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ext_eret_idle got %b want 0", int_req); end
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL ext_rereq got %b want 1", int_req); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL ext_eret_in_req got %b want 1", int_req); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    irq_in = '0;
  endtask

  task automatic test_timer();
    do_reset();
    status = 32'h0000_FF01;
    write_reg(2'd1, 32'd3);
    write_reg(2'd0, 32'd0);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 9) irq_in[5] = 1'b1;
      if (i == 12) begin
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 32'd3) begin bad++; $display("FAIL tmr_count got %h want 3", rd_data); end
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'hA0) begin bad++; $display("FAIL tmr_pending got %h want a0", rd_data); end
        total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL tmr_int_early got %b want 0", timer_int); end
      end
      if (i == 13) begin
        total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL tmr_int got %b want 1", timer_int); end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL tmr_req got %b want 1", int_req); end
        total++; if (int_line !== 3'd7) begin bad++; $display("FAIL tmr_line got %0d want 7", int_line); end
      end
    end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL tmr_ack_req got %b want 0", int_req); end
    total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL tmr_ack_keep got %b want 1", timer_int); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL tmr_rereq got %b want 1", int_req); end
    total++; if (int_line !== 3'd7) begin bad++; $display("FAIL tmr_rereq_line got %0d want 7", int_line); end
    write_reg(2'd1, 32'hFFFF_FFFF);
    rd_addr = 2'd2; #1;
    total++; if (rd_data !== 32'h20) begin bad++; $display("FAIL tmr_cmp_clear got %h want 20", rd_data); end
    @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL tmr_withdraw got %b want 0", int_req); end
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL tmr_next_req got %b want 1", int_req); end
    total++; if (int_line !== 3'd5) begin bad++; $display("FAIL tmr_next_line got %0d want 5", int_line); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    irq_in = '0;
  endtask

  task automatic test_priority_ie();
    do_reset();
    status  = 32'h0000_1400;
    rd_addr = 2'd2;
    @(negedge clk);
    irq_in[2] = 1'b1;
    irq_in[4] = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_ie_off got %b want 0", int_req); end
    total++; if (rd_data !== 32'h14) begin bad++; $display("FAIL prio_pending got %h want 14", rd_data); end
    status = 32'h0000_1401;
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req got %b want 1", int_req); end
    total++; if (int_line !== 3'd4) begin bad++; $display("FAIL prio_first got %0d want 4", int_line); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    total++; if (rd_data !== 32'h04) begin bad++; $display("FAIL prio_ack_pending got %h want 04", rd_data); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_second_req got %b want 1", int_req); end
    total++; if (int_line !== 3'd2) begin bad++; $display("FAIL prio_second got %0d want 2", int_line); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    irq_in = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    status  = 32'h0000_0801;
    rd_addr = 2'd2;
    @(negedge clk);
    irq_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL wd_req got %b want 1", int_req); end
    total++; if (int_line !== 3'd3) begin bad++; $display("FAIL wd_line got %0d want 3", int_line); end
    status = 32'h0000_0001;
    @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wd_drop got %b want 0", int_req); end
    total++; if (rd_data !== 32'h08) begin bad++; $display("FAIL wd_keep_pending got %h want 08", rd_data); end
    status = 32'h0000_0801;
    @(negedge clk);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL wd_rereq got %b want 1", int_req); end
    int_ack = 1'b1;
    status  = 32'h0000_0001;
    @(negedge clk);
    int_ack = 1'b0;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL wd_ack_wins got %h want 0", rd_data); end
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    irq_in[3] = 1'b0;
    status = 32'h0000_0800;
    @(negedge clk);
    irq_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rd_data !== 32'h08) begin bad++; $display("FAIL wd_pend_again got %h want 08", rd_data); end
    write_reg(2'd2, 32'h0000_0008);
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL wd_w1c got %h want 0", rd_data); end
    irq_in = '0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    status = 32'h0000_8001;
    write_reg(2'd1, 32'd0);
    write_reg(2'd0, 32'hFFFF_FFFF);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) begin
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got %h want ffffffff", rd_data); end
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL wrap_pre_pend got %h want 0", rd_data); end
      end
      if (i == 4) begin
        rd_addr = 2'd0; #1;
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL wrap_count got %h want 0", rd_data); end
        rd_addr = 2'd2; #1;
        total++; if (rd_data !== 32'h80) begin bad++; $display("FAIL wrap_pend got %h want 80", rd_data); end
      end
      if (i == 5) begin
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL wrap_req got %b want 1", int_req); end
        total++; if (timer_int !== 1'b1) begin bad++; $display("FAIL wrap_tint got %b want 1", timer_int); end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got %b want 0", int_req); end
    total++; if (timer_int !== 1'b0) begin bad++; $display("FAIL mid_rst_tint got %b want 0", timer_int); end
    total++; if (int_line !== 3'd0) begin bad++; $display("FAIL mid_rst_line got %0d want 0", int_line); end
    rd_addr = 2'd1; #1;
    total++; if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_rst_cmp got %h want ffffffff", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL post_rst_req got %b want 0", int_req); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    irq_in  = '0;
    status  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    int_ack = 1'b0;
    eret    = 1'b0;
    test_reset();
    test_ext_irq();
    test_timer();
    test_priority_ie();
    test_withdraw();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_intr_ctrl.md
# cp0_intr_ctrl

Interrupt source unit directly upstream of CP0 in the MIPS54 multi-cycle core. It synchronises external interrupt lines, runs a Count/Compare timer, and holds pending bits. It also prioritises unmasked requests and presents one request at a time to the controller/CP0 over a req/ack handshake. The controller turns an acknowledged request into an `exception` with cause Int (0) toward CP0; this block tracks the service window until `eret`.

## Interface
- `NUM_IRQ`, 6: external interrupt lines, mapped to lines 0..NUM_IRQ-1. Legal range 1..7.
- `DIV`, 4: timer prescale ratio; Count increments once every DIV clocks. Legal when ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq_in` in NUM_IRQ: asynchronous level lines from peripherals.
- `status` in 32: CP0 Status. Bit 0 = IE. Bit 8+k = mask for line k. Timer is line 7 (bit 15).
- `wr_en` in 1: software register write (mtc0-path decode).
- `wr_addr` in 2: 0 = COUNT, 1 = COMPARE, 2 = PENDING (write-1-to-clear), 3 = reserved (ignored).
- `wr_data` in 32: write data.
- `rd_addr` in 2: read select, same map. Reserved address reads 0.
- `rd_data` out 32: combinational read of the selected register. PENDING reads as bits [7:0].
- `int_req` out 1: interrupt request to the controller.
- `int_line` out 3: index of the line being requested.
- `int_ack` in 1: one-cycle pulse; the controller has taken the exception.
- `eret` in 1: one-cycle pulse; the handler returned.
- `timer_int` out 1: registered copy of timer pending (pending[7]).

## Operation
- **Sync:** each `irq_in` bit passes through a 2-flop synchroniser, then a rising-edge detector. A detected edge sets `pending[k]`.
- **Timer:**
  - Prescaler counts 0..DIV-1. On wrap, COUNT increments modulo 2^32 (0xFFFFFFFF → 0).
  - If the incremented COUNT equals COMPARE, set `pending[7]`.
  - Writing COMPARE clears `pending[7]`. Writing COUNT also resets the prescaler to 0.
- **Eligible set:** pending[7:0] & status[15:8], gated by status[0].
- **Priority:** line 7 highest, then NUM_IRQ-1 down to 0.
- **FSM states:**
  - IDLE: if the eligible set is non-zero, latch the highest line into `int_line`, go to REQ.
  - REQ: `int_req`=1.
    - On `int_ack`: clear that line's pending bit (lines 0..6 only; the timer clears only via a COMPARE write) and go to SERVICE.
    - If the latched line becomes ineligible without an ack (IE or mask cleared, or PENDING cleared): drop to IDLE.
  - SERVICE: `int_req`=0. New requests are held pending. On `eret` go to IDLE.
- **Simultaneous events:**
  - Edge set and W1C clear of the same bit in one cycle: set wins.
  - COUNT write and prescaler tick in one cycle: write wins, and no match check that cycle.
  - COMPARE write and match in one cycle: pending[7] ends 0.
  - `int_ack` in the same cycle as withdrawal: ack wins.
  - `eret` outside SERVICE: ignored.

## Timing
- **Reset values:** COUNT=0, COMPARE=0xFFFFFFFF, prescaler=0, pending=0, synchronisers=0, state IDLE, `int_req`=0, `int_line`=0, `timer_int`=0.
- **External line latency:** `irq_in` rise to pending set = 3 clocks (2 sync + edge). Pending set to `int_req` high = 1 clock.
- **Timer latency:** match to `timer_int` = 1 clock after pending[7] sets.
- **Outputs:** `int_req`, `int_line` and `timer_int` are registered. `int_line` is stable for the whole REQ state.
- **Reset mid-operation:** assertion clears all state immediately, including in REQ or SERVICE. No request survives reset.

## Structure
- **Package `cp0_intr_pkg`:**
  - FSM state enum (IDLE/REQ/SERVICE).
  - Register address constants.
  - `IM_BASE`=8, `TIMER_LINE`=7, `CAUSE_INT`=5'd0.
- **Sub-module `irq_sync_edge`:** 2-flop synchroniser plus rising-edge detector, instantiated per line.

## Test plan
- Reset with `irq_in`=0 → all outputs 0. Read COMPARE → 0xFFFFFFFF. Read COUNT → 0.
- status=0x0000_0101, pulse `irq_in[0]` → `int_req`=1, `int_line`=0 four clocks later. `int_ack` → pending[0]=0, `int_req`=0. `eret` → back to IDLE.
- status=0x0000_FF01, write COMPARE=3, DIV=4 → `timer_int`=1 after 12 clocks plus 1. `int_line`=7, taking precedence over a simultaneous `irq_in[5]` edge. After ack then `eret`, the timer re-requests until COMPARE is rewritten.
- Lines 2 and 4 pending, status IE=0 → no request. Set IE → line 4 served first. After `eret`, line 2 is served.
- In REQ for line 3, clear status bit 11 → `int_req` drops next clock. Pending[3] stays 1.
- Write COUNT=0xFFFFFFFF, COMPARE=0 → after DIV clocks COUNT wraps to 0 and pending[7] sets. Deassert `rst_n` mid-REQ → `int_req`=0 immediately.
